alu_4_checker: RTL and testbench
================================

# alu_4_checker

Synthesizable self-test sequencer and response checker for the 4-bit ALU. It is the consuming end of the ALU's select/operand interface. On a start pulse it drives all 16 {S2,S1,S0,Cin} combinations with latched operands. After a programmable settle time it samples G and Cout and compares them against an internal golden model. It then reports pass/fail, an error count and a per-vector fail map.

## Interface
- SETTLE, 2: cycles each vector is held before G/Cout are sampled; legal range 1..15.
- CLK  input  1  single clock; all state updates on the rising edge.
- RSTn  input  1  reset, asynchronous and active-low.
- Start  input  1  run request; sampled only in IDLE.
- OpA  input  4  operand A; latched on the accepted Start.
- OpB  input  4  operand B; latched on the accepted Start.
- S2, S1, S0  output  1 each  ALU select outputs; registered.
- Cin  output  1  ALU carry-in; registered.
- A, B  output  4 each  ALU operand outputs; registered copies of the latched OpA/OpB.
- G  input  4  ALU result under test.
- Cout  input  1  ALU carry-out under test.
- Busy  output  1  high while a run is in progress.
- Done  output  1  one-cycle pulse when a run completes.
- Pass  output  1  high when ErrCount==0; valid from Done, held until the next accepted Start.
- ErrCount  output  5  number of failing vectors, 0..16.
- FailVec  output  16  bit k set when vector k failed.

## Operation
- Vector index k = {S2,S1,S0,Cin}, swept from 0 to 15; S2 is the MSB.
- Golden model, arithmetic (S2=0), using a 5-bit sum {Cout,G}:
  - S1S0=00: A+Cin.
  - S1S0=01: A+B+Cin.
  - S1S0=10: A+~B+Cin.
  - S1S0=11: A+4'b1111+Cin.
- Golden model, logic (S2=1); Cin is ignored and expected Cout=0:
  - S1S0=00: A&B.
  - S1S0=01: A|B.
  - S1S0=10: A^B.
  - S1S0=11: ~A.
- A vector fails if G or Cout mismatches the golden value.
- FSM IDLE:
  - Start=1: latch OpA/OpB, drive vector 0, clear ErrCount and FailVec, settle counter=0, go to RUN.
- FSM RUN:
  - The settle counter increments each cycle.
  - When counter==SETTLE-1, the next edge samples G/Cout for vector k and updates ErrCount/FailVec[k].
  - If k<15, that same edge drives vector k+1 and clears the counter.
  - If k==15, that edge goes to DONE instead.
- FSM DONE:
  - Done=1 for exactly one cycle, then go to IDLE.
  - S/Cin/A/B hold the last vector; ErrCount, FailVec and Pass hold their values.
- Start while Busy or in DONE is ignored.
- Start held high continuously: a new run is accepted on the first IDLE cycle after Done.

## Timing
- Reset (asynchronous, any state) forces:
  - state=IDLE;
  - S2/S1/S0/Cin=0, A=B=0;
  - Busy=0, Done=0, Pass=0, ErrCount=0, FailVec=0.
- Reset mid-run aborts the run; Done is never pulsed for an aborted run.
- Edge T0 accepts Start:
  - vector k is driven at edge T0+k*SETTLE;
  - vector k is sampled at edge T0+(k+1)*SETTLE, the same edge that drives vector k+1.
- Busy goes high at T0 and low at T0+16*SETTLE.
- Done is high during the cycle after edge T0+16*SETTLE.
- Total run length: 16*SETTLE+1 cycles from T0 back to IDLE.
- G/Cout are sampled only at sample edges; the ALU is combinational and must settle within SETTLE cycles.
- ErrCount saturates naturally at 16; no wrap is possible.

## Test plan
- Reset checks:
  - Assert RSTn=0 mid-clock → all outputs 0 immediately.
  - Release reset, hold Start=0 for 10 cycles → Busy stays 0 and Done never pulses.
- Fault-free ALU, OpA=4'b1111, OpB=4'b0001, SETTLE=2:
  - S/Cin sequence 0..15, with a new vector every 2 cycles.
  - Expected G/Cout per vector: 1111/0, 0000/1, 0000/1, 0001/1, 1101/1, 1110/1, 1110/1, 1111/1, 0001/0, 0001/0, 1111/0, 1111/0, 1110/0, 1110/0, 0000/0, 0000/0.
  - Done pulses after edge T0+32; Pass=1, ErrCount=0, FailVec=0.
- Same stimulus, Cout stuck-at-0 → FailVec=16'h00FE, ErrCount=7, Pass=0.
- Same stimulus, G[0] stuck-at-1 → FailVec=16'hF066, ErrCount=8, Pass=0.
- Start pulsed at vector 3, and Start held high throughout:
  - the first run is unaffected and Done pulses once;
  - with Start held high, a second run begins on the cycle after Done returns to IDLE.
- Reset at vector 5, then a new Start with SETTLE=1:
  - all outputs are 0 after reset and no Done pulse occurs;
  - the full run completes in 16 sample edges with correct results.

Source files
------------

// File: rtl/alu_4_checker.sv
// alu_4_checker: sweeps all 16 {S2,S1,S0,Cin} vectors into a 4-bit ALU with latched
// operands, samples G/Cout after SETTLE cycles and scores them against a golden model.
module alu_4_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Start,
  input  logic [3:0]  OpA,
  input  logic [3:0]  OpB,
  output logic        S2,
  output logic        S1,
  output logic        S0,
  output logic        Cin,
  output logic [3:0]  A,
  output logic [3:0]  B,
  input  logic [3:0]  G,
  input  logic        Cout,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [4:0]  ErrCount,
  output logic [15:0] FailVec
);

  // state | meaning
  // IDLE  | waiting for Start; results of the previous run held
  // RUN   | driving vector k, sampling G/Cout once the settle count expires
  // DONE  | one-cycle Done pulse; vector and results held
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_vec;
  logic [3:0]  r_cnt;
  logic [3:0]  r_a;
  logic [3:0]  r_b;
  logic [4:0]  r_err;
  logic [15:0] r_fail;
  logic        r_pass;
  logic        w_accept;
  logic        w_sample;
  logic        w_last;
  logic [3:0]  w_opnd;
  logic [4:0]  w_sum;
  logic [4:0]  w_exp;
  logic        w_mismatch;
  logic [4:0]  w_err_next;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LP_CNT_LAST) begin
          w_sample = 1'b1;
          if (r_vec == 4'hF) begin
            w_last       = 1'b1;
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Golden model: r_vec = {S2,S1,S0,Cin}; arithmetic ops share one 5-bit adder.
  always_comb begin
    w_opnd = 4'h0;
    case (r_vec[2:1])
      2'b00:   w_opnd = 4'h0;
      2'b01:   w_opnd = r_b;
      2'b10:   w_opnd = ~r_b;
      default: w_opnd = 4'hF;
    endcase
    w_sum = {1'b0, r_a} + {1'b0, w_opnd} + {4'b0000, r_vec[0]};
    w_exp = w_sum;
    if (r_vec[3]) begin
      case (r_vec[2:1])
        2'b00:   w_exp = {1'b0, r_a & r_b};
        2'b01:   w_exp = {1'b0, r_a | r_b};
        2'b10:   w_exp = {1'b0, r_a ^ r_b};
        default: w_exp = {1'b0, ~r_a};
      endcase
    end
  end

  assign w_mismatch = (G != w_exp[3:0]) || (Cout != w_exp[4]);
  assign w_err_next = r_err + {4'b0000, w_mismatch};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_vec  <= 4'h0;
      r_cnt  <= 4'h0;
      r_a    <= 4'h0;
      r_b    <= 4'h0;
      r_err  <= 5'd0;
      r_fail <= 16'h0000;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_a    <= OpA;
      r_b    <= OpB;
      r_vec  <= 4'h0;
      r_cnt  <= 4'h0;
      r_err  <= 5'd0;
      r_fail <= 16'h0000;
      r_pass <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (w_sample) begin
        r_err  <= w_err_next;
        r_fail <= r_fail | (16'(w_mismatch) << r_vec);
        r_cnt  <= 4'h0;
        // The last sample edge holds vector 15 and publishes the verdict with Done.
        if (w_last) r_pass <= (w_err_next == 5'd0);
        else        r_vec  <= r_vec + 4'h1;
      end else begin
        r_cnt <= r_cnt + 4'h1;
      end
    end
  end

  assign {S2, S1, S0, Cin} = r_vec;
  assign A        = r_a;
  assign B        = r_b;
  assign Busy     = (r_state == ST_RUN);
  assign Done     = (r_state == ST_DONE);
  assign Pass     = r_pass;
  assign ErrCount = r_err;
  assign FailVec  = r_fail;

endmodule

// File: tb/tb_alu_4_checker.sv
// Directed bench for alu_4_checker: two instances (SETTLE=2 and SETTLE=1), each driving
// a behavioural ALU with optional stuck-at faults on Cout or G[0].
module tb_alu_4_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SETTLE=2 instance
  logic        rst2_n, start2;
  logic [3:0]  opa2, opb2;
  logic        d2_s2, d2_s1, d2_s0, d2_cin;
  logic [3:0]  d2_a, d2_b, d2_g;
  logic        d2_cout, d2_busy, d2_done, d2_pass;
  logic [4:0]  d2_err;
  logic [15:0] d2_fail;
  logic [3:0]  vec2;
  logic [4:0]  alu2_r;
  int          fault2 = 0;

  // SETTLE=1 instance
  logic        rst1_n, start1;
  logic [3:0]  opa1, opb1;
  logic        d1_s2, d1_s1, d1_s0, d1_cin;
  logic [3:0]  d1_a, d1_b, d1_g;
  logic        d1_cout, d1_busy, d1_done, d1_pass;
  logic [4:0]  d1_err;
  logic [15:0] d1_fail;
  logic [3:0]  vec1;
  logic [4:0]  alu1_r;
  int          fault1 = 0;

  alu_4_checker #(.SETTLE(2)) u_dut2 (
    .CLK(clk), .RSTn(rst2_n), .Start(start2), .OpA(opa2), .OpB(opb2),
    .S2(d2_s2), .S1(d2_s1), .S0(d2_s0), .Cin(d2_cin), .A(d2_a), .B(d2_b),
    .G(d2_g), .Cout(d2_cout), .Busy(d2_busy), .Done(d2_done), .Pass(d2_pass),
    .ErrCount(d2_err), .FailVec(d2_fail)
  );

  alu_4_checker #(.SETTLE(1)) u_dut1 (
    .CLK(clk), .RSTn(rst1_n), .Start(start1), .OpA(opa1), .OpB(opb1),
    .S2(d1_s2), .S1(d1_s1), .S0(d1_s0), .Cin(d1_cin), .A(d1_a), .B(d1_b),
    .G(d1_g), .Cout(d1_cout), .Busy(d1_busy), .Done(d1_done), .Pass(d1_pass),
    .ErrCount(d1_err), .FailVec(d1_fail)
  );

  assign vec2 = {d2_s2, d2_s1, d2_s0, d2_cin};
  assign vec1 = {d1_s2, d1_s1, d1_s0, d1_cin};

  // Behavioural ALU under test; returns {Cout,G}
  function automatic logic [4:0] alu_model(input logic [2:0] s, input logic cin,
                                            input logic [3:0] a, input logic [3:0] b);
    logic [4:0] c5;
    c5 = {4'b0000, cin};
    case (s)
      3'd0:    return {1'b0, a} + c5;
      3'd1:    return {1'b0, a} + {1'b0, b} + c5;
      3'd2:    return {1'b0, a} + {1'b0, ~b} + c5;
      3'd3:    return {1'b0, a} + 5'd15 + c5;
      3'd4:    return {1'b0, a & b};
      3'd5:    return {1'b0, a | b};
      3'd6:    return {1'b0, a ^ b};
      default: return {1'b0, ~a};
    endcase
  endfunction

  always_comb begin
    alu2_r  = alu_model({d2_s2, d2_s1, d2_s0}, d2_cin, d2_a, d2_b);
    d2_g    = alu2_r[3:0];
    d2_cout = alu2_r[4];
    if (fault2 == 1) d2_cout = 1'b0;
    if (fault2 == 2) d2_g[0] = 1'b1;
  end

  always_comb begin
    alu1_r  = alu_model({d1_s2, d1_s1, d1_s0}, d1_cin, d1_a, d1_b);
    d1_g    = alu1_r[3:0];
    d1_cout = alu1_r[4];
    if (fault1 == 1) d1_cout = 1'b0;
    if (fault1 == 2) d1_g[0] = 1'b1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Ticks from the accepting edge until Done; n==100 means Done never came.
  task automatic wait_done2(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!d2_done && n < 100);
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!d1_done && n < 100);
  endtask

  task automatic test_reset;
    bit seen;
    checks++;
    if ({vec2, d2_a, d2_b, d2_busy, d2_done, d2_pass, d2_err, d2_fail} !== 36'h0) begin
      errors++;
      $display("FAIL reset_state2: got %h expected 0",
               {vec2, d2_a, d2_b, d2_busy, d2_done, d2_pass, d2_err, d2_fail});
    end
    checks++;
    if ({vec1, d1_a, d1_b, d1_busy, d1_done, d1_pass, d1_err, d1_fail} !== 36'h0) begin
      errors++;
      $display("FAIL reset_state1: got %h expected 0",
               {vec1, d1_a, d1_b, d1_busy, d1_done, d1_pass, d1_err, d1_fail});
    end
    rst2_n = 1'b1;
    rst1_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (d2_busy || d2_done || d1_busy || d1_done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_activity: got busy/done seen=%0d expected 0", seen);
    end
    // Abort a run with an asynchronous reset between clock edges.
    opa2 = 4'hF; opb2 = 4'h1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (3) tick();
    #3 rst2_n = 1'b0;
    #1;
    checks++;
    if ({vec2, d2_a, d2_b, d2_busy, d2_done, d2_pass, d2_err, d2_fail} !== 36'h0) begin
      errors++;
      $display("FAIL async_reset_midrun: got %h expected 0",
               {vec2, d2_a, d2_b, d2_busy, d2_done, d2_pass, d2_err, d2_fail});
    end
    tick();
    rst2_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (d2_done || d2_busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL aborted_run_no_done: got seen=%0d expected 0", seen);
    end
  endtask

  task automatic test_fault_free;
    logic [3:0] exp_g [16];
    logic       exp_c [16];
    int         bad;
    exp_g = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b1101, 4'b1110, 4'b1110, 4'b1111,
              4'b0001, 4'b0001, 4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b0000, 4'b0000};
    exp_c = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fault2 = 0;
    opa2 = 4'b1111; opb2 = 4'b0001; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    opa2 = 4'h0; opb2 = 4'h0;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 2; j++) begin
        if (vec2 !== 4'(k) || d2_busy !== 1'b1 || d2_done !== 1'b0 ||
            d2_a !== 4'hF || d2_b !== 4'h1 || d2_g !== exp_g[k] || d2_cout !== exp_c[k]) begin
          bad++;
          $display("FAIL vector_seq k=%0d j=%0d: got vec=%h busy=%b done=%b A=%h B=%h G=%b Cout=%b expected vec=%h busy=1 done=0 A=f B=1 G=%b Cout=%b",
                   k, j, vec2, d2_busy, d2_done, d2_a, d2_b, d2_g, d2_cout, 4'(k), exp_g[k], exp_c[k]);
        end
        tick();
      end
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if ({d2_done, d2_busy, d2_pass, d2_err, d2_fail, vec2} !== {1'b1, 1'b0, 1'b1, 5'd0, 16'h0, 4'hF}) begin
      errors++;
      $display("FAIL done_at_T0+32: got done=%b busy=%b pass=%b err=%0d fail=%h vec=%h expected 1 0 1 0 0000 f",
               d2_done, d2_busy, d2_pass, d2_err, d2_fail, vec2);
    end
    tick();
    checks++;
    if ({d2_done, d2_busy, d2_pass, d2_err, d2_fail} !== {1'b0, 1'b0, 1'b1, 5'd0, 16'h0}) begin
      errors++;
      $display("FAIL after_done_hold: got done=%b busy=%b pass=%b err=%0d fail=%h expected 0 0 1 0 0000",
               d2_done, d2_busy, d2_pass, d2_err, d2_fail);
    end
  endtask

  task automatic test_cout_stuck;
    int n;
    fault2 = 1;
    opa2 = 4'hF; opb2 = 4'h1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_done2(n);
    checks++;
    if (n != 32 || d2_fail !== 16'h00FE || d2_err !== 5'd7 || d2_pass !== 1'b0) begin
      errors++;
      $display("FAIL cout_stuck0: got n=%0d fail=%h err=%0d pass=%b expected 32 00fe 7 0",
               n, d2_fail, d2_err, d2_pass);
    end
    tick();
    fault2 = 0;
  endtask

  task automatic test_g0_stuck;
    int n;
    fault2 = 2;
    opa2 = 4'hF; opb2 = 4'h1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_done2(n);
    checks++;
    if (n != 32 || d2_fail !== 16'hF066 || d2_err !== 5'd8 || d2_pass !== 1'b0) begin
      errors++;
      $display("FAIL g0_stuck1: got n=%0d fail=%h err=%0d pass=%b expected 32 f066 8 0",
               n, d2_fail, d2_err, d2_pass);
    end
    tick();
    fault2 = 0;
  endtask

  task automatic test_start_while_busy;
    int n;
    int dones;
    bit busy_after;
    opa2 = 4'hF; opb2 = 4'h1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (6) tick();
    checks++;
    if (vec2 !== 4'd3) begin
      errors++;
      $display("FAIL reach_vector3: got %h expected 3", vec2);
    end
    opa2 = 4'h0; opb2 = 4'h0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 7;
    while (!d2_done && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 32 || d2_pass !== 1'b1 || d2_err !== 5'd0 || d2_a !== 4'hF || d2_b !== 4'h1) begin
      errors++;
      $display("FAIL start_ignored_run: got n=%0d pass=%b err=%0d A=%h B=%h expected 32 1 0 f 1",
               n, d2_pass, d2_err, d2_a, d2_b);
    end
    dones = 0;
    busy_after = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (d2_done) dones++;
      if (d2_busy) busy_after = 1'b1;
    end
    checks++;
    if (dones != 0 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got extra_dones=%0d busy=%b expected 0 0", dones, busy_after);
    end
  endtask

  task automatic test_start_held;
    int n;
    opa2 = 4'hF; opb2 = 4'h1; start2 = 1'b1;
    tick();
    wait_done2(n);
    checks++;
    if (n != 32 || d2_pass !== 1'b1) begin
      errors++;
      $display("FAIL held_first_run: got n=%0d pass=%b expected 32 1", n, d2_pass);
    end
    tick();
    checks++;
    if (d2_busy !== 1'b0 || d2_done !== 1'b0) begin
      errors++;
      $display("FAIL held_idle_cycle: got busy=%b done=%b expected 0 0", d2_busy, d2_done);
    end
    tick();
    checks++;
    if (d2_busy !== 1'b1 || vec2 !== 4'h0 || d2_pass !== 1'b0) begin
      errors++;
      $display("FAIL held_restart: got busy=%b vec=%h pass=%b expected 1 0 0", d2_busy, vec2, d2_pass);
    end
    start2 = 1'b0;
    wait_done2(n);
    checks++;
    if (n != 32 || d2_pass !== 1'b1 || d2_fail !== 16'h0) begin
      errors++;
      $display("FAIL held_second_run: got n=%0d pass=%b fail=%h expected 32 1 0000", n, d2_pass, d2_fail);
    end
    tick();
  endtask

  task automatic test_reset_settle1;
    int n;
    bit seen;
    fault1 = 0;
    opa1 = 4'h6; opb1 = 4'hA; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (5) tick();
    checks++;
    if (vec1 !== 4'd5 || d1_busy !== 1'b1) begin
      errors++;
      $display("FAIL s1_reach_vector5: got vec=%h busy=%b expected 5 1", vec1, d1_busy);
    end
    #3 rst1_n = 1'b0;
    #1;
    checks++;
    if ({vec1, d1_a, d1_b, d1_busy, d1_done, d1_pass, d1_err, d1_fail} !== 36'h0) begin
      errors++;
      $display("FAIL s1_async_reset: got %h expected 0",
               {vec1, d1_a, d1_b, d1_busy, d1_done, d1_pass, d1_err, d1_fail});
    end
    repeat (2) tick();
    rst1_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (d1_done || d1_busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL s1_no_done_after_abort: got seen=%0d expected 0", seen);
    end
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done1(n);
    checks++;
    if (n != 16 || d1_pass !== 1'b1 || d1_err !== 5'd0 || d1_fail !== 16'h0 ||
        d1_a !== 4'h6 || d1_b !== 4'hA) begin
      errors++;
      $display("FAIL s1_full_run: got n=%0d pass=%b err=%0d fail=%h A=%h B=%h expected 16 1 0 0000 6 a",
               n, d1_pass, d1_err, d1_fail, d1_a, d1_b);
    end
    tick();
  endtask

  task automatic test_settle1_cout_stuck;
    int n;
    fault1 = 1;
    opa1 = 4'h6; opb1 = 4'hA; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done1(n);
    checks++;
    if (n != 16 || d1_fail !== 16'h00CC || d1_err !== 5'd4 || d1_pass !== 1'b0) begin
      errors++;
      $display("FAIL s1_cout_stuck0: got n=%0d fail=%h err=%0d pass=%b expected 16 00cc 4 0",
               n, d1_fail, d1_err, d1_pass);
    end
    tick();
    fault1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst2_n = 1'b0; start2 = 1'b0; opa2 = 4'h0; opb2 = 4'h0;
    rst1_n = 1'b0; start1 = 1'b0; opa1 = 4'h0; opb1 = 4'h0;
    repeat (3) tick();
    test_reset();
    test_fault_free();
    test_cout_stuck();
    test_g0_stuck();
    test_start_while_busy();
    test_start_held();
    test_reset_settle1();
    test_settle1_cout_stuck();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
